// File: rtl/cart_rom_cache_pkg.sv
// cart_rom_cache_pkg: shared constants, widths and the controller state type
// for the cartridge ROM read cache.
//   ADDR_W     - NES-side byte address width (PRG/CHR decode)
//   FLASH_AW   - flash byte address width
//   INDEX_W    - image slot index width
//   tag_width  - tag bits left after line/word/byte fields are removed
package cart_rom_cache_pkg;

  localparam int ADDR_W         = 17;
  localparam int FLASH_AW       = 24;
  localparam int INDEX_W        = 4;
  localparam int BYTE_W         = 2;   // byte lane bits inside a 32-bit word
  localparam int LINES_DEF      = 64;
  localparam int LINE_WORDS_DEF = 4;

  function automatic int tag_width(input int lines, input int line_words);
    return ADDR_W - $clog2(lines) - $clog2(line_words) - BYTE_W;
  endfunction

  typedef enum logic [2:0] {
    ST_FLUSH,
    ST_IDLE,
    ST_LOOKUP,
    ST_FILL,
    ST_RESPOND
  } state_e;

endpackage

// File: rtl/cart_rom_cache_if.sv
// cart_rom_cache_if: groups the cartridge-side read port, the reload control
// and the flash burst port of the cache.
//   slave  - the cache: consumes reload/index/req/addr/fill_*, drives the rest
//   master - the cartridge decode + flash reader side
// Handshake: req is held with a stable addr until ready pulses for one
// cycle; rdata is valid in that cycle. fill_req is held until the first
// fill_valid; every fill_valid cycle carries one line word, in order.
interface cart_rom_cache_if;
  import cart_rom_cache_pkg::*;

  logic                reload;
  logic [INDEX_W-1:0]  index;
  logic                req;
  logic [ADDR_W-1:0]   addr;
  logic                ready;
  logic [7:0]          rdata;
  logic                busy;
  logic                fill_req;
  logic [FLASH_AW-1:0] fill_addr;
  logic                fill_valid;
  logic [31:0]         fill_data;

  modport slave (
    input  reload, index, req, addr, fill_valid, fill_data,
    output ready, rdata, busy, fill_req, fill_addr
  );

  modport master (
    output reload, index, req, addr, fill_valid, fill_data,
    input  ready, rdata, busy, fill_req, fill_addr
  );

endinterface

// File: rtl/cart_rom_cache_line_ram.sv
// cache_line_ram: simple dual-port synchronous RAM holding cache line words.
//   clk   - clock
//   we    - write enable, waddr/wdata written on the clock edge
//   raddr - read address, rdata is registered (valid the cycle after)
// Read-during-write to the same address returns the old contents.
module cache_line_ram #(
  parameter int AW = 8,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/cart_rom_cache.sv
// cart_rom_cache: direct-mapped read cache between the cartridge address
// decode and the QSPI flash word reader. Misses fetch a whole line as a
// burst; reload (new cartridge) invalidates everything.
//   clock, reset - single clock, synchronous active-high reset
//   bus          - cart_rom_cache_if.slave (req/addr/ready/rdata, reload,
//                  busy, fill_req/fill_addr/fill_valid/fill_data)
//   dbg_state    - current controller state
module cart_rom_cache
  import cart_rom_cache_pkg::*;
#(
  parameter logic [FLASH_AW-1:0] FLASH_BASE = 24'h100000,
  parameter int                  LINE_WORDS = LINE_WORDS_DEF,
  parameter int                  LINES      = LINES_DEF
) (
  input  logic              clock,
  input  logic              reset,
  cart_rom_cache_if.slave   bus,
  output state_e            dbg_state
);

  localparam int WORD_W = $clog2(LINE_WORDS);
  localparam int LINE_W = $clog2(LINES);
  localparam int OFF_W  = WORD_W + BYTE_W;
  localparam int TAG_W  = tag_width(LINES, LINE_WORDS);
  localparam int RAM_AW = LINE_W + WORD_W;

  state_e              state_q, state_d;
  logic [LINE_W-1:0]   flush_cnt_q, flush_cnt_d;
  logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
  logic [INDEX_W-1:0]  index_lat_q, index_lat_d;
  logic [WORD_W-1:0]   word_cnt_q, word_cnt_d;
  logic                abort_q, abort_d;     // reload seen during this fill
  logic                fwd_sel_q, fwd_sel_d; // respond from fill word, not RAM
  logic [31:0]         fwd_q, fwd_d;
  logic                fill_req_q, fill_req_d;
  logic [FLASH_AW-1:0] fill_addr_q, fill_addr_d;
  logic                ready_q, ready_d;
  logic [7:0]          rdata_q, rdata_d;
  logic                busy_q, busy_d;

  logic [LINES-1:0]    valid_q;
  logic [TAG_W-1:0]    tag_q [LINES];

  logic                ram_we, valid_clr, tag_we, hit;
  logic [RAM_AW-1:0]   ram_waddr, ram_raddr;
  logic [31:0]         ram_rdata, word_sel;
  logic [TAG_W-1:0]    req_tag;
  logic [LINE_W-1:0]   req_line;
  logic [WORD_W-1:0]   req_word;
  logic [BYTE_W-1:0]   req_byte;
  logic [ADDR_W-1:0]   line_base;

  assign req_tag   = req_addr_q[ADDR_W-1 -: TAG_W];
  assign req_line  = req_addr_q[OFF_W +: LINE_W];
  assign req_word  = req_addr_q[BYTE_W +: WORD_W];
  assign req_byte  = req_addr_q[BYTE_W-1:0];
  assign line_base = {req_addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign hit       = valid_q[req_line] && (tag_q[req_line] == req_tag);
  // The last fill word is written in the same cycle the RAM would have to
  // read it, so a filled request answers from the captured word instead.
  assign word_sel  = fwd_sel_q ? fwd_q : ram_rdata;
  assign ram_raddr = {req_line, req_word};
  assign ram_waddr = {req_line, word_cnt_q};

  cache_line_ram #(.AW(RAM_AW), .DW(32)) u_ram (
    .clk   (clock),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (bus.fill_data),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    req_addr_d  = req_addr_q;
    index_lat_d = index_lat_q;
    word_cnt_d  = word_cnt_q;
    abort_d     = abort_q;
    fwd_sel_d   = fwd_sel_q;
    fwd_d       = fwd_q;
    fill_req_d  = fill_req_q;
    fill_addr_d = fill_addr_q;
    ready_d     = 1'b0;
    rdata_d     = rdata_q;
    ram_we      = 1'b0;
    valid_clr   = 1'b0;
    tag_we      = 1'b0;

    case (state_q)
      ST_FLUSH: begin
        valid_clr = 1'b1;
        if (bus.reload) begin
          index_lat_d = bus.index;
          flush_cnt_d = '0;
        end else if (flush_cnt_q == LINE_W'(LINES - 1)) begin
          state_d = ST_IDLE;
        end else begin
          flush_cnt_d = flush_cnt_q + LINE_W'(1);
        end
      end
      ST_IDLE: begin
        if (bus.reload) begin
          index_lat_d = bus.index;
          flush_cnt_d = '0;
          state_d     = ST_FLUSH;
        end else if (bus.req) begin
          req_addr_d = bus.addr;
          state_d    = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (bus.reload) begin
          index_lat_d = bus.index;
          flush_cnt_d = '0;
          state_d     = ST_FLUSH;
        end else if (hit) begin
          fwd_sel_d = 1'b0;
          state_d   = ST_RESPOND;
        end else begin
          fill_req_d  = 1'b1;
          fill_addr_d = FLASH_BASE + (FLASH_AW'(index_lat_q) << 18)
                        + FLASH_AW'(line_base);
          word_cnt_d  = '0;
          abort_d     = 1'b0;
          state_d     = ST_FILL;
        end
      end
      ST_FILL: begin
        // The flash burst cannot be aborted: a reload only marks the line
        // as not-to-be-validated and the burst still runs to completion.
        if (bus.reload) begin
          abort_d     = 1'b1;
          index_lat_d = bus.index;
        end
        if (bus.fill_valid) begin
          fill_req_d = 1'b0;
          ram_we     = 1'b1;
          word_cnt_d = word_cnt_q + WORD_W'(1);
          if (word_cnt_q == req_word) begin
            fwd_d = bus.fill_data;
          end
          if (word_cnt_q == WORD_W'(LINE_WORDS - 1)) begin
            if (abort_q || bus.reload) begin
              flush_cnt_d = '0;
              state_d     = ST_FLUSH;
            end else begin
              tag_we    = 1'b1;
              fwd_sel_d = 1'b1;
              state_d   = ST_RESPOND;
            end
          end
        end
      end
      ST_RESPOND: begin
        if (bus.reload) begin
          index_lat_d = bus.index;
          flush_cnt_d = '0;
          state_d     = ST_FLUSH;
        end else begin
          ready_d = 1'b1;
          rdata_d = word_sel[{req_byte, 3'b000} +: 8];
          state_d = ST_IDLE;
        end
      end
      default: begin
        flush_cnt_d = '0;
        state_d     = ST_FLUSH;
      end
    endcase

    busy_d = (state_d == ST_FLUSH) || (state_d == ST_FILL);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_FLUSH;
      flush_cnt_q <= '0;
      req_addr_q  <= '0;
      index_lat_q <= '0;
      word_cnt_q  <= '0;
      abort_q     <= 1'b0;
      fwd_sel_q   <= 1'b0;
      fwd_q       <= '0;
      fill_req_q  <= 1'b0;
      fill_addr_q <= '0;
      ready_q     <= 1'b0;
      rdata_q     <= '0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      req_addr_q  <= req_addr_d;
      index_lat_q <= index_lat_d;
      word_cnt_q  <= word_cnt_d;
      abort_q     <= abort_d;
      fwd_sel_q   <= fwd_sel_d;
      fwd_q       <= fwd_d;
      fill_req_q  <= fill_req_d;
      fill_addr_q <= fill_addr_d;
      ready_q     <= ready_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
    end
  end

  // Tag/valid array has no reset: the FLUSH pass after reset clears it.
  always_ff @(posedge clock) begin
    if (valid_clr) begin
      valid_q[flush_cnt_q] <= 1'b0;
    end
    if (tag_we) begin
      valid_q[req_line] <= 1'b1;
      tag_q[req_line]   <= req_tag;
    end
  end

  assign bus.ready     = ready_q;
  assign bus.rdata     = rdata_q;
  assign bus.busy      = busy_q;
  assign bus.fill_req  = fill_req_q;
  assign bus.fill_addr = fill_addr_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_cart_rom_cache.sv
module tb_cart_rom_cache;
  import cart_rom_cache_pkg::*;

  logic   clk;
  logic   rst;
  state_e dbg_state;

  cart_rom_cache_if bus();

  cart_rom_cache dut (
    .clock     (clk),
    .reset     (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [3:0] idx_model;

  typedef struct {
    logic [16:0] addr;
    bit          exp_miss;
    bit          gaps;
  } vec_t;

  vec_t vecs[12];

  // ---------------- clock / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] flash_word(input logic [23:0] fa);
    if (fa == 24'h100010) return 32'h44332211;
    if (fa >= 24'h100014 && fa <= 24'h10001C) return 32'h0;
    return {fa[7:0] ^ 8'h5A, fa[15:8] + fa[7:0], fa[23:16] ^ fa[7:0], fa[7:0] + 8'h3C};
  endfunction

  function automatic logic [23:0] fill_base(input logic [16:0] a, input logic [3:0] idx);
    return 24'h100000 + ({20'h0, idx} << 18) + {3'b000, a[16:4], 4'b0000};
  endfunction

  function automatic logic [7:0] exp_byte(input logic [16:0] a, input logic [3:0] idx);
    logic [31:0] w;
    w = flash_word(fill_base(a, idx) + {20'h0, a[3:2], 2'b00});
    return w[{a[1:0], 3'b000} +: 8];
  endfunction

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic do_read(input logic [16:0] a, input bit exp_miss, input bit gaps);
    logic [23:0] fa;
    logic [7:0]  e;
    int          cyc;
    int          k;
    bit          saw_fill;
    bit          got;
    bit          drop_chk;
    bit          phase;
    fa = fill_base(a, idx_model);
    exp_q.push_back(exp_byte(a, idx_model));
    bus.req  = 1'b1;
    bus.addr = a;
    cyc = 0; k = 0; saw_fill = 0; got = 0; drop_chk = 0; phase = 1;
    while (!got && cyc < 200) begin
      @(negedge clk);
      cyc++;
      bus.fill_valid = 1'b0;
      if (bus.ready) begin
        got = 1;
      end else begin
        if (saw_fill && k > 0 && !drop_chk) begin
          chk($sformatf("fill_req_drop a=%h", a), 32'(bus.fill_req), 32'd0);
          drop_chk = 1;
        end
        if (bus.fill_req && !saw_fill) begin
          saw_fill = 1;
          chk($sformatf("fill_addr a=%h", a), 32'(bus.fill_addr), 32'(fa));
        end
        if (saw_fill && k < 4) begin
          if (!gaps || phase) begin
            bus.fill_valid = 1'b1;
            bus.fill_data  = flash_word(fa + 24'(4 * k));
            k++;
          end
          phase = ~phase;
        end
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL read_timeout a=%h: got no ready expected ready", a);
      void'(exp_q.pop_front());
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("rdata a=%h", a), 32'(bus.rdata), 32'(e));
      chk($sformatf("miss a=%h", a), 32'(saw_fill), 32'(exp_miss));
      if (!exp_miss) chk($sformatf("hit_latency a=%h", a), 32'(cyc), 32'd3);
    end
    bus.req = 1'b0;
    @(negedge clk);
    chk($sformatf("ready_pulse a=%h", a), 32'(bus.ready), 32'd0);
  endtask

  task automatic wait_flush(input string name);
    int n;
    bit saw_ready;
    n = 0;
    saw_ready = 0;
    while (bus.busy && n < 300) begin
      if (bus.ready) saw_ready = 1;
      n++;
      @(negedge clk);
    end
    chk({name, "_cycles"}, 32'(n), 32'd64);
    chk({name, "_no_ready"}, 32'(saw_ready), 32'd0);
  endtask

  task automatic wait_fill_req(input string name);
    int n;
    n = 0;
    while (!bus.fill_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_fill_req"}, 32'(bus.fill_req), 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    bit saw_ready;
    rst = 1'b1;
    bus.reload = 1'b0; bus.index = '0; bus.req = 1'b0; bus.addr = '0;
    bus.fill_valid = 1'b0; bus.fill_data = '0;
    idx_model = 4'd0;

    vecs[0]  = '{17'h00010, 1, 0};
    vecs[1]  = '{17'h00013, 0, 0};
    vecs[2]  = '{17'h00410, 1, 0};
    vecs[3]  = '{17'h00010, 1, 0};
    vecs[4]  = '{17'h00014, 0, 0};
    vecs[5]  = '{17'h1FFFF, 1, 1};
    vecs[6]  = '{17'h1FFFC, 0, 0};
    vecs[7]  = '{17'h0003E, 1, 1};
    vecs[8]  = '{17'h00030, 0, 0};
    vecs[9]  = '{17'h00410, 1, 0};
    vecs[10] = '{17'h1FC00, 1, 0};
    vecs[11] = '{17'h00417, 0, 0};

    repeat (3) @(negedge clk);
    chk("reset_ready",     32'(bus.ready),     32'd0);
    chk("reset_rdata",     32'(bus.rdata),     32'd0);
    chk("reset_busy",      32'(bus.busy),      32'd1);
    chk("reset_fill_req",  32'(bus.fill_req),  32'd0);
    chk("reset_fill_addr", 32'(bus.fill_addr), 32'd0);
    chk("reset_state",     32'(dbg_state),     32'(ST_FLUSH));

    // Request raised while the boot flush is still running.
    rst = 1'b0;
    bus.req  = 1'b1;
    bus.addr = 17'h00010;
    wait_flush("boot_flush");

    for (int i = 0; i < 12; i++) begin
      do_read(vecs[i].addr, vecs[i].exp_miss, vecs[i].gaps);
    end

    // reload with index 3 in the middle of a fill burst
    bus.req = 1'b1; bus.addr = 17'h00800;
    wait_fill_req("rl_fill");
    chk("rl_fill_addr", 32'(bus.fill_addr), 32'h100800);
    saw_ready = 0;
    bus.fill_valid = 1'b1; bus.fill_data = 32'hA0A0A0A0;
    @(negedge clk);
    bus.fill_valid = 1'b0; bus.reload = 1'b1; bus.index = 4'd3; bus.req = 1'b0;
    @(negedge clk);
    bus.reload = 1'b0;
    for (int k = 1; k < 4; k++) begin
      if (bus.ready) saw_ready = 1;
      bus.fill_valid = 1'b1; bus.fill_data = 32'hA0A0A0A0 + 32'(k);
      @(negedge clk);
    end
    bus.fill_valid = 1'b0;
    chk("rl_fill_no_ready", 32'(saw_ready), 32'd0);
    idx_model = 4'd3;
    wait_flush("rl_fill_flush");
    do_read(17'h10000, 1, 0);
    chk("rl_idx3_fill_addr", 32'(bus.fill_addr), 32'h1D0000);
    do_read(17'h00010, 1, 0);

    // reload with index 0 while idle
    bus.reload = 1'b1; bus.index = 4'd0;
    @(negedge clk);
    bus.reload = 1'b0;
    idx_model = 4'd0;
    wait_flush("rl_idle_flush");
    do_read(17'h10000, 1, 0);
    do_read(17'h10001, 0, 0);

    // reset (with a simultaneous reload) in the middle of a fill burst
    bus.req = 1'b1; bus.addr = 17'h00020;
    wait_fill_req("rst_fill");
    bus.fill_valid = 1'b1; bus.fill_data = 32'h12345678;
    @(negedge clk);
    bus.fill_valid = 1'b0; rst = 1'b1; bus.reload = 1'b1; bus.index = 4'd5; bus.req = 1'b0;
    @(negedge clk);
    rst = 1'b0; bus.reload = 1'b0;
    chk("rst_fill_req",  32'(bus.fill_req), 32'd0);
    chk("rst_busy",      32'(bus.busy),     32'd1);
    chk("rst_state",     32'(dbg_state),    32'(ST_FLUSH));
    bus.fill_valid = 1'b1; bus.fill_data = 32'hDEADBEEF;
    wait_flush("rst_flush");
    bus.fill_valid = 1'b0;
    idx_model = 4'd0;
    do_read(17'h00020, 1, 0);
    do_read(17'h00013, 1, 0);
    do_read(17'h10001, 1, 0);
    do_read(17'h10002, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
